// File: rtl/player_motion_ctrl.sv
// -----------------------------------------------------------------------------
// player_motion_ctrl
//   Per-frame sequencer for the player sprite. Once per rising edge of
//   frame_tick it walks the sprite left/right, runs jump/gravity, resolves
//   landing on the floor or on the one-way platform, and picks the sprite-sheet
//   frame. All outputs update together, exactly 3 clk after the clock edge
//   that first samples frame_tick high, and hold steady between updates.
//
// Ports
//   clk          in   1   pixel clock
//   rst          in   1   asynchronous active-high reset
//   frame_tick   in   1   level from the VGA timing; rising edge = one update
//   buttons      in   8   active-low; [0] right, [1] left, [3] up/jump,
//                         [7] A/jump; all other bits ignored
//   char_x       out  10  sprite top-left x
//   char_y       out  10  sprite top-left y
//   facing_right out  1   1 = mirror the sheet column
//   anim_row     out  10  sheet row offset (0 or 30)
//   anim_col     out  10  sheet column offset (0, 23, 46)
//   airborne     out  1   1 while the feet are not supported
// -----------------------------------------------------------------------------
module player_motion_ctrl #(
  parameter int SCREEN_W  = 640,
  parameter int SPR_W     = 46,
  parameter int SPR_H     = 60,
  parameter int START_X   = 64,
  parameter int GROUND_Y  = 460,
  parameter int PLT_X     = 270,
  parameter int PLT_Y     = 300,
  parameter int PLT_W     = 100,
  parameter int WALK_STEP = 5,
  parameter int JUMP_VEL  = 12,
  parameter int GRAVITY   = 1,
  parameter int MAX_FALL  = 10,
  parameter int ANIM_DIV  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [7:0] buttons,
  output logic [9:0] char_x,
  output logic [9:0] char_y,
  output logic       facing_right,
  output logic [9:0] anim_row,
  output logic [9:0] anim_col,
  output logic       airborne
);

  typedef enum logic [1:0] {S_WAIT, S_CALC_X, S_CALC_Y, S_COMMIT} seq_e;
  typedef enum logic [1:0] {A_IDLE, A_WALK, A_AIR} anim_e;

  // Constants sized to the datapath they are compared against.
  localparam logic [10:0]       X_MAX     = 11'(SCREEN_W - SPR_W);
  localparam logic [10:0]       STEP11    = 11'(WALK_STEP);
  localparam logic [10:0]       SPR_W11   = 11'(SPR_W);
  localparam logic [10:0]       PLT_X11   = 11'(PLT_X);
  localparam logic [10:0]       PLT_END11 = 11'(PLT_X + PLT_W);
  localparam logic [9:0]        START_X10 = 10'(START_X);
  localparam logic [9:0]        Y_REST    = 10'(GROUND_Y - SPR_H);
  localparam logic [9:0]        Y_PLAT    = 10'(PLT_Y - SPR_H);
  localparam logic signed [11:0] SPR_H_S  = 12'(SPR_H);
  localparam logic signed [11:0] GROUND_S = 12'(GROUND_Y);
  localparam logic signed [11:0] PLT_Y_S  = 12'(PLT_Y);
  localparam logic signed [11:0] JUMP_S   = 12'(JUMP_VEL);
  localparam logic signed [7:0] VY_GRAV   = 8'(GRAVITY);
  localparam logic signed [7:0] VY_MAX    = 8'(MAX_FALL);
  // Take-off already applies the first gravity step, so the second airborne
  // tick rises by JUMP_VEL-GRAVITY (400 -> 388 -> 377 -> 367 ...).
  localparam logic signed [7:0] VY_TAKEOFF = 8'(GRAVITY - JUMP_VEL);
  localparam logic [7:0]        DIV_LAST  = 8'(ANIM_DIV - 1);
  // Sheet cells are the unscaled sprite size.
  localparam logic [9:0]        SHEET_ROW  = 10'(SPR_H / 2);
  localparam logic [9:0]        SHEET_COL  = 10'(SPR_W / 2);
  localparam logic [9:0]        SHEET_COL2 = 10'(2 * (SPR_W / 2));

  // Only four buttons matter; the rest are deliberately dropped.
  logic unused_buttons;
  assign unused_buttons = ^{buttons[6:4], buttons[2]};

  // Synchronised buttons, packed as {A, up, left, right}, still active-low.
  logic [3:0] btn_meta_q, btn_sync_q;
  logic       tick_q;
  seq_e       seq_q;

  // Working copies of the motion state; outputs only follow them in COMMIT.
  logic [9:0]        x_q, y_q;
  logic signed [7:0] vy_q;
  logic              air_q, facing_q, moved_q;
  logic              jump_prev_q, jump_edge_q;

  anim_e      amode_q;
  logic [2:0] idx_q;
  logic [7:0] div_q;

  logic tick_edge, go_right, go_left, jump;
  assign tick_edge = frame_tick & ~tick_q;
  assign go_right  = ~btn_sync_q[0];
  assign go_left   = ~btn_sync_q[1];
  assign jump      = ~btn_sync_q[2] | ~btn_sync_q[3];

  // ---------------------------------------------------------------------------
  // Horizontal step (consumed in CALC_X)
  // ---------------------------------------------------------------------------
  logic [10:0] x_ext, x_plus;
  logic [9:0]  x_d;
  logic        facing_d;

  assign x_ext  = {1'b0, x_q};
  assign x_plus = x_ext + STEP11;

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    x_d      = x_q;
    facing_d = facing_q;
    if (go_right && !go_left) begin
      facing_d = 1'b1;
      x_d      = (x_plus > X_MAX) ? X_MAX[9:0] : x_plus[9:0];
    end else if (go_left && !go_right) begin
      facing_d = 1'b0;
      x_d      = (x_ext < STEP11) ? 10'd0 : x_q - STEP11[9:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Vertical step (consumed in CALC_Y, x_q already holds the new x)
  // ---------------------------------------------------------------------------
  logic signed [11:0] y_s, y_new, y_jump, feet_now, feet_new;
  logic signed [7:0]  vy_grav;
  logic               overlap, support;
  logic [9:0]         y_d;
  logic signed [7:0]  vy_d;
  logic               air_d;

  assign y_s      = $signed({2'b00, y_q});
  assign y_new    = y_s + 12'(vy_q);
  assign y_jump   = y_s - JUMP_S;
  assign feet_now = y_s + SPR_H_S;
  assign feet_new = y_new + SPR_H_S;
  assign vy_grav  = (vy_q >= VY_MAX) ? VY_MAX : vy_q + VY_GRAV;
  assign overlap  = ((x_ext + SPR_W11) > PLT_X11) && (x_ext < PLT_END11);
  assign support  = (feet_now == GROUND_S) || ((feet_now == PLT_Y_S) && overlap);

  always_comb begin
    y_d   = y_q;
    vy_d  = vy_q;
    air_d = air_q;
    if (!air_q) begin
      if (jump_edge_q) begin
        y_d   = (y_jump < 0) ? 10'd0 : y_jump[9:0];
        vy_d  = VY_TAKEOFF;
        air_d = 1'b1;
      end else if (!support) begin
        // Walked off the platform edge: start falling from rest.
        vy_d  = '0;
        air_d = 1'b1;
      end
    end else begin
      // One-way platform: only a falling sprite whose feet start at or above
      // the top edge can land; it is checked before the floor so it wins.
      if (vy_q > 0 && overlap && feet_now <= PLT_Y_S && feet_new >= PLT_Y_S) begin
        y_d   = Y_PLAT;
        vy_d  = '0;
        air_d = 1'b0;
      end else if (vy_q > 0 && feet_new >= GROUND_S) begin
        y_d   = Y_REST;
        vy_d  = '0;
        air_d = 1'b0;
      end else if (y_new < 0) begin
        y_d  = '0;
        vy_d = '0;
      end else begin
        y_d  = y_new[9:0];
        vy_d = vy_grav;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Animation (consumed in COMMIT on the final state of this tick)
  // ---------------------------------------------------------------------------
  anim_e      amode_d;
  logic [2:0] idx_d;
  logic [7:0] div_d;
  logic [9:0] row_d, col_d;

  always_comb begin
    amode_d = amode_q;
    idx_d   = idx_q;
    div_d   = div_q;
    row_d   = '0;
    col_d   = '0;
    if (air_q) begin
      amode_d = A_AIR;
    end else if (moved_q) begin
      amode_d = A_WALK;
      if (amode_q != A_WALK) begin
        idx_d = '0;
        div_d = '0;
      end else if (div_q == DIV_LAST) begin
        div_d = '0;
        idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      end else begin
        div_d = div_q + 8'd1;
      end
    end else begin
      amode_d = A_IDLE;
    end

    if (amode_d == A_AIR) begin
      row_d = SHEET_ROW;
    end else if (amode_d == A_WALK) begin
      case (idx_d)
        3'd1:    col_d = SHEET_COL;
        3'd2:    col_d = SHEET_COL2;
        3'd3:    row_d = SHEET_ROW;
        3'd4:    begin row_d = SHEET_ROW; col_d = SHEET_COL;  end
        3'd5:    begin row_d = SHEET_ROW; col_d = SHEET_COL2; end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer and all state
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Synchroniser resets to "released" so reset never looks like a press.
      btn_meta_q   <= '1;
      btn_sync_q   <= '1;
      tick_q       <= 1'b0;
      seq_q        <= S_WAIT;
      x_q          <= START_X10;
      y_q          <= Y_REST;
      vy_q         <= '0;
      air_q        <= 1'b0;
      facing_q     <= 1'b1;
      moved_q      <= 1'b0;
      jump_prev_q  <= 1'b0;
      jump_edge_q  <= 1'b0;
      amode_q      <= A_IDLE;
      idx_q        <= '0;
      div_q        <= '0;
      char_x       <= START_X10;
      char_y       <= Y_REST;
      facing_right <= 1'b1;
      anim_row     <= '0;
      anim_col     <= '0;
      airborne     <= 1'b0;
    end else begin
      btn_meta_q <= {buttons[7], buttons[3], buttons[1], buttons[0]};
      btn_sync_q <= btn_meta_q;
      tick_q     <= frame_tick;

      case (seq_q)
        S_WAIT: begin
          // Edges seen in any other state are simply lost.
          if (tick_edge) seq_q <= S_CALC_X;
        end
        S_CALC_X: begin
          x_q         <= x_d;
          facing_q    <= facing_d;
          moved_q     <= (x_d != x_q);
          jump_edge_q <= jump & ~jump_prev_q;
          jump_prev_q <= jump;
          seq_q       <= S_CALC_Y;
        end
        S_CALC_Y: begin
          y_q   <= y_d;
          vy_q  <= vy_d;
          air_q <= air_d;
          seq_q <= S_COMMIT;
        end
        S_COMMIT: begin
          char_x       <= x_q;
          char_y       <= y_q;
          facing_right <= facing_q;
          airborne     <= air_q;
          anim_row     <= row_d;
          anim_col     <= col_d;
          amode_q      <= amode_d;
          idx_q        <= idx_d;
          div_q        <= div_d;
          seq_q        <= S_WAIT;
        end
        default: seq_q <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_player_motion_ctrl.sv
// -----------------------------------------------------------------------------
// tb_player_motion_ctrl
//   Scoreboard bench for player_motion_ctrl. Stimulus tasks issue frame ticks
//   and push the reference model's predicted outputs, stamped with the cycle
//   they must appear on, into a queue. A monitor compares the DUT outputs on
//   every falling clock edge against the most recently due prediction, so
//   both the commit latency and the hold-steady behaviour are covered.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_player_motion_ctrl;

  localparam logic [7:0] BTN_NONE = 8'hFF;
  localparam logic [7:0] BTN_R    = 8'hFE;
  localparam logic [7:0] BTN_L    = 8'hFD;
  localparam logic [7:0] BTN_RL   = 8'hFC;
  localparam logic [7:0] BTN_UP   = 8'hF7;
  localparam logic [7:0] BTN_A    = 8'h7F;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic [7:0] buttons;
  logic [9:0] char_x, char_y, anim_row, anim_col;
  logic       facing_right, airborne;

  player_motion_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .buttons      (buttons),
    .char_x       (char_x),
    .char_y       (char_y),
    .facing_right (facing_right),
    .anim_row     (anim_row),
    .anim_col     (anim_col),
    .airborne     (airborne)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int x;
    int y;
    int fr;
    int row;
    int col;
    int air;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Reference model: plain integer rules for one frame update.
  // ---------------------------------------------------------------------------
  int m_x, m_y, m_vy, m_fr, m_air, m_mode, m_idx, m_div, m_jprev, m_row, m_col;

  task automatic model_reset();
    m_x = 64; m_y = 400; m_vy = 0; m_fr = 1; m_air = 0;
    m_mode = 0; m_idx = 0; m_div = 0; m_jprev = 0; m_row = 0; m_col = 0;
  endtask

  task automatic model_step(input logic [7:0] b);
    bit r, l, j, jedge, moved, ovl;
    int nx, ny, nvy;
    r = !b[0];
    l = !b[1];
    j = !b[3] || !b[7];
    jedge = j && !m_jprev;
    m_jprev = j;

    nx = m_x;
    if (r && !l) begin
      nx = (m_x + 5 > 594) ? 594 : m_x + 5;
      m_fr = 1;
    end else if (l && !r) begin
      nx = (m_x < 5) ? 0 : m_x - 5;
      m_fr = 0;
    end
    moved = (nx != m_x);
    m_x = nx;
    ovl = (m_x + 46 > 270) && (m_x < 370);

    if (!m_air) begin
      if (jedge) begin
        m_y = m_y - 12;
        m_vy = -11;
        m_air = 1;
      end else if (!((m_y + 60 == 460) || (m_y + 60 == 300 && ovl))) begin
        m_vy = 0;
        m_air = 1;
      end
    end else begin
      ny = m_y + m_vy;
      nvy = (m_vy + 1 > 10) ? 10 : m_vy + 1;
      if (m_vy > 0 && ovl && m_y + 60 <= 300 && ny + 60 >= 300) begin
        m_y = 240; m_vy = 0; m_air = 0;
      end else if (m_vy > 0 && ny + 60 >= 460) begin
        m_y = 400; m_vy = 0; m_air = 0;
      end else if (ny < 0) begin
        m_y = 0; m_vy = 0;
      end else begin
        m_y = ny; m_vy = nvy;
      end
    end

    if (m_air) begin
      m_mode = 2; m_row = 30; m_col = 0;
    end else if (moved) begin
      if (m_mode != 1) begin
        m_idx = 0; m_div = 0;
      end else begin
        m_div++;
        if (m_div == 6) begin
          m_div = 0;
          m_idx = (m_idx + 1) % 6;
        end
      end
      m_mode = 1;
      m_row = (m_idx >= 3) ? 30 : 0;
      m_col = 23 * (m_idx % 3);
    end else begin
      m_mode = 0; m_row = 0; m_col = 0;
    end
  endtask

  function automatic exp_t snapshot(input int c);
    exp_t e;
    e.cyc = c; e.x = m_x; e.y = m_y; e.fr = m_fr;
    e.row = m_row; e.col = m_col; e.air = m_air;
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      if (sb_q[0].cyc < cyc) begin
        vectors++;
        errors++;
        $display("FAIL late_entry: due at cyc %0d, still queued at cyc %0d", sb_q[0].cyc, cyc);
      end
      cur = sb_q.pop_front();
    end
    vectors++;
    if (int'(char_x) != cur.x || int'(char_y) != cur.y || int'(facing_right) != cur.fr ||
        int'(anim_row) != cur.row || int'(anim_col) != cur.col || int'(airborne) != cur.air) begin
      errors++;
      if (errors <= 30)
        $display("FAIL outputs@cyc%0d: got x=%0d y=%0d fr=%0d row=%0d col=%0d air=%0d, want x=%0d y=%0d fr=%0d row=%0d col=%0d air=%0d",
                 cyc, char_x, char_y, facing_right, anim_row, anim_col, airborne,
                 cur.x, cur.y, cur.fr, cur.row, cur.col, cur.air);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  // Buttons settle through the synchroniser before the tick rises; the update
  // must show up on the 3rd clock after the edge that samples frame_tick high.
  task automatic do_tick(input logic [7:0] b);
    buttons = b;
    repeat (3) @(negedge clk);
    model_step(b);
    sb_q.push_back(snapshot(cyc + 4));
    frame_tick = 1'b1;
    repeat (2) @(negedge clk);
    frame_tick = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  // A second rising edge two clocks after the first lands mid-sequence and
  // must be lost.
  task automatic double_tick(input logic [7:0] b);
    buttons = b;
    repeat (3) @(negedge clk);
    model_step(b);
    sb_q.push_back(snapshot(cyc + 4));
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  // Reset lands while the sequencer is in CALC_Y: no commit may follow.
  task automatic reset_mid_update(input logic [7:0] b);
    buttons = b;
    repeat (3) @(negedge clk);
    frame_tick = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    frame_tick = 1'b0;
    buttons = BTN_NONE;
    sb_q.delete();
    model_reset();
    cur = snapshot(cyc);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    frame_tick = 1'b0;
    buttons = BTN_NONE;
    model_reset();
    cur = snapshot(0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);

    // Idle tick straight after reset.
    do_tick(BTN_NONE);

    // Long walk right: saturates at 594, animation cycles through all frames.
    repeat (200) do_tick(BTN_R);

    // Walk left into the wall, then right to x=100, then both buttons.
    repeat (125) do_tick(BTN_L);
    repeat (20) do_tick(BTN_R);
    repeat (4) do_tick(BTN_RL);

    // Jump held for a long time: only one take-off.
    repeat (30) do_tick(BTN_UP);
    do_tick(BTN_NONE);
    // Jump on the A button, then let it land.
    do_tick(BTN_A);
    repeat (25) do_tick(BTN_NONE);

    // Walk under the platform and jump there; rising must not catch the edge.
    repeat (40) do_tick(BTN_R);
    do_tick(BTN_UP);
    repeat (28) do_tick(BTN_NONE);
    repeat (20) do_tick(BTN_R);

    // Dropped second edge.
    double_tick(BTN_L);
    double_tick(BTN_NONE);

    // Randomised ticks, including jumps while moving and dropped edges.
    for (int i = 0; i < 250; i++) begin
      logic [7:0] b;
      b = 8'($urandom());
      if ($urandom_range(0, 7) == 0) double_tick(b);
      else do_tick(b);
    end

    // Move away from reset state, then reset in the middle of an update.
    repeat (3) do_tick(BTN_L);
    reset_mid_update(BTN_R);
    repeat (3) do_tick(BTN_NONE);
    do_tick(BTN_R);

    repeat (10) @(negedge clk);
    vectors++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d entries left, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #5ms;
    errors++;
    $display("FAIL watchdog: run did not complete, cyc=%0d", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
